pc_fetch_unit: RTL
==================

// Module: pc_fetch_unit
// PURPOSE
//  Multicycle fetch front end: owns the PC register and instruction register (IR).
//  Runs the instruction-memory read handshake and latches the fetched word.
//  Decodes the IR into the PC, NPCOp and IMM[25:0] inputs of the next-PC adder.
//  Commits the adder's NPC result back into the PC when the controller asserts pc_wr.
// PARAMETERS
//  RESET_PC  32'h0000_3000  byte address loaded into PC on reset; bits [1:0] ignored
//  TIMEOUT   16             max cycles in REQ waiting for imem_rdy before fault; >=1
// PORTS
//  clk         in   1    clock; all state updates on rising edge
//  rst         in   1    asynchronous, active-high reset
//  fetch_go    in   1    controller pulse: start a fetch; sampled only in IDLE
//  pc_wr       in   1    controller: commit npc_in to PC; sampled only in DECODED
//  zero        in   1    ALU zero flag, qualifies beq
//  npc_in      in   30   [31:2] next PC from the next-PC adder
//  imem_req    out  1    instruction-memory read request (level)
//  imem_addr   out  30   [31:2] word address; always equals pc
//  imem_rdy    in   1    memory: imem_rdata valid this cycle
//  imem_rdata  in   32   instruction word
//  pc          out  30   [31:2] current PC -> next-PC adder PC input
//  ir          out  32   latched instruction
//  ir_valid    out  1    ir holds an instruction not yet retired
//  npc_op      out  2    NPC_PLUS4 / NPC_BRANCH / NPC_JUMP -> next-PC adder NPCOp
//  imm26       out  26   ir[25:0] -> next-PC adder IMM
//  retired     out  32   count of committed pc_wr events
//  fetch_err   out  1    sticky: imem_rdy timeout occurred
// BEHAVIOUR
//  Reset (async, immediate, any state):
//   state=IDLE, pc=RESET_PC[31:2], ir=0, ir_valid=0, retired=0, fetch_err=0, wait counter=0.
//  FSM (registered):
//   IDLE:    fetch_go -> REQ, wait counter cleared. pc_wr ignored.
//   REQ:     imem_req=1.
//            imem_rdy -> ir<=imem_rdata, ir_valid<=1, next DECODED (one-cycle latency rdy->ir).
//            Otherwise wait counter+1; at count==TIMEOUT-1 without rdy: fetch_err<=1, next IDLE, ir unchanged.
//   DECODED: pc_wr -> pc<=npc_in, ir_valid<=0, retired<=retired+1 (wraps 2^32-1 -> 0), next IDLE.
//  Simultaneous events:
//   - fetch_go outside IDLE is ignored.
//   - pc_wr outside DECODED is ignored.
//   - fetch_go and pc_wr together in DECODED: commit only; the next fetch needs a new fetch_go.
//   - imem_rdy arriving on the timeout cycle wins: latch IR, no fault.
//  Outputs:
//   - imem_req is asserted only in REQ and is combinational from state.
//   - imem_addr, pc and imm26 follow their registers directly.
//   - npc_op is combinational from ir and zero, and is meaningful only while ir_valid=1:
//     - opcode ir[31:26]==6'b000100 (beq) && zero     -> NPC_BRANCH
//     - opcode 6'b000010 (j) or 6'b000011 (jal)       -> NPC_JUMP
//     - all else, including beq with zero=0            -> NPC_PLUS4
//  PC wraps modulo 2^30 words; npc_in is trusted and is never range-checked.
//  fetch_err does not block further fetches; it clears only on reset.
// STRUCTURE
//  Shared defines (ctrl_encode_def.v): NPC_PLUS4=2'b00, NPC_BRANCH=2'b01, NPC_JUMP=2'b10,
//   OP_BEQ, OP_J, OP_JAL, and FETCH_IDLE/FETCH_REQ/FETCH_DECODED state codes (2-bit).
//  One sub-module: npc_op_decode (ir[31:26], zero -> npc_op), combinational,
//   reusable by the control unit.
// TESTING
//  1 Reset: rst=1 mid-REQ -> next sample pc=30'h0C00, state IDLE, imem_req=0, ir_valid=0, retired=0.
//  2 Sequential fetch: fetch_go; rdy after 2 cycles, rdata=32'h2008_0005 -> ir latched, npc_op=PLUS4;
//    pc_wr with npc_in=30'h0C01 -> pc=30'h0C01, retired=1.
//  3 Branch: ir=32'h1000_0004 with zero=1 -> npc_op=BRANCH; with zero=0 -> PLUS4;
//    imm26=26'h0000004 in both cases.
//  4 Jump: rdata=32'h0C00_0C10 (jal) -> npc_op=JUMP, imm26=26'h0000C10; pc_wr commits npc_in exactly.
//  5 Timeout: TIMEOUT=16, rdy never arrives -> imem_req high 16 cycles, then fetch_err=1, IDLE;
//    a later fetch still succeeds; rdy on cycle 16 -> no fault.
//  6 Ignored controls: pc_wr in IDLE/REQ and fetch_go in REQ/DECODED -> no pc, retired or state change.

Source files
------------

// File: rtl/pc_fetch_unit_pkg.sv
// Shared encodings for the fetch front end and the next-PC path.
package pc_fetch_unit_pkg;

  // Next-PC adder operation select
  localparam logic [1:0] NPC_PLUS4  = 2'b00;
  localparam logic [1:0] NPC_BRANCH = 2'b01;
  localparam logic [1:0] NPC_JUMP   = 2'b10;

  // Opcodes that redirect control flow
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_JAL = 6'b000011;

  // Fetch controller states
  typedef enum logic [1:0] {
    FETCH_IDLE    = 2'b00,
    FETCH_REQ     = 2'b01,
    FETCH_DECODED = 2'b10
  } fetch_state_e;

endpackage

// File: rtl/pc_fetch_unit_npc_op_decode.sv
// Opcode + zero flag -> next-PC adder operation. Purely combinational so the
// control unit can reuse it.
module npc_op_decode
  import pc_fetch_unit_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic       zero,
  output logic [1:0] npc_op
);

  // beq takes the branch only when the ALU reports equality
  always_comb begin
    npc_op = NPC_PLUS4;
    if (opcode == OP_BEQ && zero) begin
      npc_op = NPC_BRANCH;
    end else if (opcode == OP_J || opcode == OP_JAL) begin
      npc_op = NPC_JUMP;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Multicycle fetch front end: PC/IR ownership, imem read handshake with
// timeout fault, IR decode towards the next-PC adder, and PC commit.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_go,
  input  logic        pc_wr,
  input  logic        zero,
  input  logic [29:0] npc_in,
  output logic        imem_req,
  output logic [29:0] imem_addr,
  input  logic        imem_rdy,
  input  logic [31:0] imem_rdata,
  output logic [29:0] pc,
  output logic [31:0] ir,
  output logic        ir_valid,
  output logic [1:0]  npc_op,
  output logic [25:0] imm26,
  output logic [31:0] retired,
  output logic        fetch_err
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);

  fetch_state_e  state;
  logic [CW-1:0] wait_cnt;

  // Fetch sequencing, PC/IR update and fault/retire bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FETCH_IDLE;
      pc        <= RESET_PC[31:2];
      ir        <= '0;
      ir_valid  <= 1'b0;
      retired   <= '0;
      fetch_err <= 1'b0;
      wait_cnt  <= '0;
    end else begin
      case (state)
        FETCH_IDLE: begin
          if (fetch_go) begin
            state    <= FETCH_REQ;
            wait_cnt <= '0;
          end
        end
        FETCH_REQ: begin
          // rdy on the final wait cycle still wins over the fault
          if (imem_rdy) begin
            ir       <= imem_rdata;
            ir_valid <= 1'b1;
            state    <= FETCH_DECODED;
          end else if (wait_cnt == LAST_WAIT) begin
            fetch_err <= 1'b1;
            state     <= FETCH_IDLE;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        FETCH_DECODED: begin
          if (pc_wr) begin
            pc       <= npc_in;
            ir_valid <= 1'b0;
            retired  <= retired + 32'd1;
            state    <= FETCH_IDLE;
          end
        end
        default: state <= FETCH_IDLE;
      endcase
    end
  end

  assign imem_req  = (state == FETCH_REQ);
  assign imem_addr = pc;
  assign imm26     = ir[25:0];

  npc_op_decode u_npc_op_decode (
    .opcode (ir[31:26]),
    .zero   (zero),
    .npc_op (npc_op)
  );

endmodule
